pipelined_array_mult: RTL and testbench

//  Parametrised, pipelined array multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or unsigned per operation.

---
 rtl/pipelined_array_mult.sv | 85 ++++++++
 tb/tb_pipelined_array_mult.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_array_mult.sv
// pipelined_array_mult: pipelined WIDTH x WIDTH array multiplier, signed/unsigned per entry,
// ROWS_PER_STAGE partial-product rows per stage, valid/ready on both sides, pass-through tag.
module pipelined_array_mult #(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2,
    parameter int TAG_W          = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);
    localparam int STAGES = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
    localparam int PW     = 2 * WIDTH;

    // Signed mode: the multiplier MSB carries weight -2^(W-1), so its row is subtracted.
    function automatic logic [PW-1:0] f_rows(input logic [PW-1:0] sum, input logic [PW-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic sgn, input int k);
        logic [PW-1:0] acc;
        acc = sum;
        for (int i = 0; i < WIDTH; i++)
            if (i / ROWS_PER_STAGE == k && b[i])
                acc = (sgn && i == WIDTH - 1) ? acc - (a << i) : acc + (a << i);
        return acc;
    endfunction

    logic [STAGES-1:0] r_v;
    logic [PW-1:0]     r_a   [STAGES];
    logic [PW-1:0]     r_p   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic              r_s   [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];
    logic              w_adv;
    logic [PW-1:0]     w_a0;
    logic [WIDTH-1:0]  w_b0;
    logic              w_s0;

    assign w_adv     = !out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES-1];
    assign out_p     = r_p[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign busy      = |r_v;
    // Bubbles are loaded as zero operands so they carry a zero product down the pipe.
    assign w_a0 = in_valid ? {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a} : '0;
    assign w_b0 = in_valid ? in_b : '0;
    assign w_s0 = in_valid & in_signed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_p[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= 1'b0;
                r_tag[k] <= '0;
            end
        end else if (w_adv) begin
            r_v[0]   <= in_valid;
            r_a[0]   <= w_a0;
            r_b[0]   <= w_b0;
            r_s[0]   <= w_s0;
            r_tag[0] <= in_valid ? in_tag : '0;
            r_p[0]   <= f_rows('0, w_a0, w_b0, w_s0, 0);
            for (int k = 1; k < STAGES; k++) begin
                r_v[k]   <= r_v[k-1];
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_s[k]   <= r_s[k-1];
                r_tag[k] <= r_tag[k-1];
                r_p[k]   <= f_rows(r_p[k-1], r_a[k-1], r_b[k-1], r_s[k-1], k);
            end
        end
    end
endmodule

// File: tb/tb_pipelined_array_mult.sv
// tb_pipelined_array_mult: table-driven vectors, directed stall/reset sequences and random traffic,
// checked against a scoreboard queue filled at accept time.
module tb_pipelined_array_mult;
    localparam int W  = 8;
    localparam int T  = 2;
    localparam int ST = 4;

    logic clk = 1'b0, rst, in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [W-1:0]   in_a, in_b;
    logic [T-1:0]   in_tag, out_tag;
    logic [2*W-1:0] out_p;

    typedef struct { logic [15:0] p; logic [T-1:0] tag; int c; } exp_t;
    typedef struct { logic [7:0] a; logic [7:0] b; logic s; logic [T-1:0] tag; logic [15:0] p; } vec_t;

    exp_t q[$];
    exp_t e;
    vec_t vt[10];
    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_lat = 0, run_rand = 0;
    logic [15:0] hp;
    logic [T-1:0] ht;

    pipelined_array_mult #(.WIDTH(W), .ROWS_PER_STAGE(2), .TAG_W(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int x, y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got p=%h tag=%0d expected no result", out_p, out_tag);
            end else begin
                e = q.pop_front();
                chk("product_tag", {14'd0, out_tag, out_p}, {14'd0, e.tag, e.p});
                if (chk_lat) chk("latency", cyc - e.c, ST);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [T-1:0] tag, input logic [15:0] p);
        in_a = a; in_b = b; in_signed = s; in_tag = tag; in_valid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 1);
        else q.push_back('{p, tag, cyc});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && q.size() != 0; t++) begin
            @(negedge clk); #1;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_tag = 0; out_ready = 1'b1;
        vt[0] = '{8'hFF, 8'hFF, 1'b0, 2'd1, 16'hFE01};
        vt[1] = '{8'h80, 8'h80, 1'b1, 2'd2, 16'h4000};
        vt[2] = '{8'hFF, 8'h7F, 1'b1, 2'd3, 16'hFF81};
        vt[3] = '{8'h80, 8'hFF, 1'b0, 2'd0, 16'h7F80};
        vt[4] = '{8'h80, 8'hFF, 1'b1, 2'd1, 16'h0080};
        vt[5] = '{8'h00, 8'h5A, 1'b1, 2'd2, 16'h0000};
        vt[6] = '{8'h7F, 8'h7F, 1'b1, 2'd3, 16'h3F01};
        vt[7] = '{8'hFF, 8'hFF, 1'b1, 2'd0, 16'h0001};
        vt[8] = '{8'h80, 8'h7F, 1'b1, 2'd1, 16'hC080};
        vt[9] = '{8'h0C, 8'h0D, 1'b0, 2'd2, 16'h009C};
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_p", {16'd0, out_p}, 0);
        chk("rst_out_tag", {30'd0, out_tag}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        chk_lat = 1;
        foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].s, vt[i].tag, vt[i].p);
        drain();
        chk_lat = 0;

        fork
            for (int i = 0; i < 8; i++)
                send(8'(i * 17 + 3), 8'(i * 29 + 129), i[0], 2'(i), model(8'(i * 17 + 3), 8'(i * 29 + 129), i[0]));
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                hp = out_p; ht = out_tag;
                chk("stall_out_valid", {31'd0, out_valid}, 1);
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 0);
                    chk("stall_out_p", {16'd0, out_p}, {16'd0, hp});
                    chk("stall_out_tag", {30'd0, out_tag}, {30'd0, ht});
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) send(8'(i + 5), 8'(i + 9), 1'b0, 2'(i), model(8'(i + 5), 8'(i + 9), 1'b0));
        chk("pre_rst_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 0);
        chk("async_rst_busy", {31'd0, busy}, 0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 1);
        q.delete();
        @(negedge clk) rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_no_out", {31'd0, out_valid}, 0);
        end
        @(posedge clk); #1;

        run_rand = 1;
        fork
            while (run_rand) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(3) != 0);
            end
        join_none
        for (int i = 0; i < 10000; i++) begin
            logic [7:0] a, b;
            logic s;
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            if ($urandom_range(3) == 0) begin
                @(posedge clk); #1;
            end
            send(a, b, s, 2'(i), model(a, b, s));
        end
        run_rand = 0;
        @(posedge clk); #2 out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
